// File: rtl/mips32_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mips32_prog_loader                                             |
// | Purpose : Streams a program image into the MIPS32 instruction and data   |
// |           memories, then releases the processor. It regains control when |
// |           the processor halts, so the processor can be reloaded.         |
// | Ports   : clk1        - single clock, rising edge                        |
// |           rst         - asynchronous active-high reset                   |
// |           s_valid/s_ready/s_data - upstream load-word stream             |
// |           mem_we/mem_sel/mem_addr/mem_wdata - memory write port          |
// |                         (mem_sel 0 = instruction, 1 = data)              |
// |           cpu_run     - processor release (fetch from PC 0)              |
// |           cpu_halted  - processor HALTED flag                            |
// |           busy        - a load is in progress                            |
// |           load_err    - sticky error, cleared only by rst                |
// | Config  : define LOADER_CHECKSUM_EN to require an XOR checksum word      |
// |           after each payload block.                                      |
// | Header  : [31:28] sync 4'hA, [27] target, [25:16] base, [9:0] count      |
// |           (count 0 = end of load); bits [26] and [15:10] are ignored.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mips32_prog_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_run,
   input  logic              cpu_halted,
   output logic              busy,
   output logic              load_err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      PAYLOAD = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      CSUM    = 3'd3,
`endif
      RUN     = 3'd4,
      DONE    = 3'd5,
      ERR     = 3'd6
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic                target;
   logic [ADDR_W-1:0]   base;
   logic [9:0]          count;
   logic [9:0]          index;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0]   csum;
`endif

   logic                accept;
   logic                hdr_ok;
   logic                last_word;
   logic                unused_hdr_bits;

   assign accept          = s_valid & s_ready;
   assign hdr_ok          = (s_data[31:28] == 4'hA);
   assign last_word       = (index == (count - 10'd1));
   assign unused_hdr_bits = ^{s_data[26], s_data[15:10]};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = HDR;
         HDR, DONE: begin
            if (accept) begin
               if (!hdr_ok)                 state_nx = ERR;
               else if (s_data[9:0] == '0)  state_nx = RUN;
               else                         state_nx = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (accept && last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_nx = CSUM;
`else
               state_nx = HDR;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) state_nx = (s_data == csum) ? HDR : ERR;
         end
`endif
         RUN:     if (cpu_halted) state_nx = DONE;
         ERR:     state_nx = ERR;
         default: state_nx = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they change
   // together with the state register.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         cpu_run   <= 1'b0;
         load_err  <= 1'b0;
         mem_we    <= 1'b0;
         mem_sel   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         target    <= 1'b0;
         base      <= '0;
         count     <= '0;
         index     <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state    <= state_nx;
         s_ready  <= (state_nx == HDR) || (state_nx == PAYLOAD) ||
`ifdef LOADER_CHECKSUM_EN
                     (state_nx == CSUM) ||
`endif
                     (state_nx == DONE);
         busy     <= (state_nx == HDR) ||
`ifdef LOADER_CHECKSUM_EN
                     (state_nx == CSUM) ||
`endif
                     (state_nx == PAYLOAD);
         cpu_run  <= (state_nx == RUN);
         load_err <= (state_nx == ERR);
         mem_we   <= 1'b0;

         if (accept) begin
            case (state)
               HDR, DONE: begin
                  target <= s_data[27];
                  base   <= ADDR_W'(s_data[25:16]);
                  count  <= s_data[9:0];
                  index  <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum   <= '0;
`endif
               end
               PAYLOAD: begin
                  // Address wraps naturally at the ADDR_W boundary.
                  mem_we    <= 1'b1;
                  mem_sel   <= target;
                  mem_addr  <= base + ADDR_W'(index);
                  mem_wdata <= s_data;
                  index     <= index + 10'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum      <= csum ^ s_data;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
